dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed, big-endian data memory (1024 bytes, one registered read cycle).
- Port 0 is the pipeline MEM stage; port 1 is the program loader/debug port.
- Grants at most one access per cycle and drives the memory's f3/addr/data/Wmem/Rmem lines.
- Rejects illegal or out-of-range accesses before they reach memory, and returns exactly one response per accepted transaction to the requester that issued it.

Parameters:
- DEPTH, 1024, memory size in bytes; legal byte addresses are 0..DEPTH-1.
- MAX_WAIT, 8, consecutive cycles port 1 may be held off before it is forced to win.
- CW, 4, width of the starvation counter; must satisfy 2^CW > MAX_WAIT.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_write  in  2  per-port direction: 1 = store, 0 = load.
- req_f3  in  6  per-port funct3; port i uses bits [3i+2:3i].
- req_addr  in  64  per-port byte address; port i uses bits [32i+31:32i].
- req_data  in  64  per-port store data, same slicing as req_addr.
- req_ready  out  2  per-port grant; combinational in the same cycle.
- rsp_valid  out  2  per-port one-cycle response pulse.
- rsp_err  out  1  response is an error; qualified by rsp_valid.
- rsp_data  out  32  load result; 0 for stores and errors.
- mem_f3  out  3  to memory f3.
- mem_addr  out  32  to memory addr.
- mem_data  out  32  to memory data.
- mem_Wmem  out  1  to memory Wmem.
- mem_Rmem  out  1  to memory Rmem.
- mem_memOut  in  32  from memory memOut.

Behaviour:
- Handshake:
  - A transfer occurs on port i when req_valid[i] and req_ready[i] are both high at a rising Clock edge.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] is never high while req_valid[i] is low.
  - A requester holds its request stable until it is accepted.
- Arbitration (combinational, from valids and the starvation counter):
  - Default priority is port 0.
  - Port 1 wins when port 0 is idle, or when starve_cnt == MAX_WAIT.
- Starvation counter:
  - Increments each cycle port 1 is valid and not granted.
  - Clears when port 1 is granted or port 1 is not valid.
  - Saturates at MAX_WAIT.
- Access size, decoded from f3:
  - 000 and 100 are 1 byte.
  - 001 and 101 are 2 bytes.
  - 010 is 4 bytes.
  - f3 = 011/110/111 is illegal. f3 = 100/101 on a store is also illegal.
- Range check: addr + size > DEPTH, computed in 33-bit arithmetic so that addr near 2^32 cannot wrap, is an error. Misalignment inside range is legal.
- Memory drive, in the grant cycle only:
  - mem_Wmem = granted and write and legal.
  - mem_Rmem = granted and !write and legal.
  - mem_f3, mem_addr and mem_data come from the granted port.
  - With no grant or an error, both enables are 0 and the buses are 0.
- Response:
  - Registered tag captures {valid, port, write, err} at the transfer edge.
  - In the next cycle rsp_valid[tag.port] = 1.
  - rsp_err = tag.err.
  - rsp_data = mem_memOut for a legal load, otherwise 0.
- Throughput and latency:
  - Back-to-back transfers are allowed every cycle.
  - Latency is fixed: the response appears exactly 1 cycle after acceptance.
- Reset:
  - Asynchronous assertion clears the tag, starve_cnt, rsp_valid, rsp_err and rsp_data to 0.
  - req_ready and the mem_* outputs go to 0 while nReset is low.
  - A transaction accepted on the edge before reset asserts loses its response.
- With DEPTH=1024, addr=1023 and a 2-byte access is an error (1025 > 1024), while addr=1020 and a word access is legal.

Test Plan:
- Port 0 store word 0xDEADBEEF at addr 0x10, then load word at 0x10 → memory sees Wmem with f3=010; next cycle rsp_valid=01 with err=0; load response rsp_data=0xDEADBEEF on port 0.
- Both ports valid continuously with MAX_WAIT=8 → port 0 granted 8 consecutive cycles, port 1 granted on cycle 9, starve_cnt cleared, port 0 resumes.
- Port 1 load byte f3=000 at addr 0x20 holding 0x80 → rsp_valid=10, rsp_data=0xFFFFFF80; with f3=100 the result is 0x00000080.
- Port 0 load word at addr 1022 → accepted, mem_Rmem=0, next cycle rsp_valid=01, rsp_err=1, rsp_data=0; repeat with addr=0xFFFFFFFE → error, no wrap.
- Port 0 store with f3=101 → rsp_err=1, mem_Wmem never asserted, memory contents unchanged on readback.
- Load accepted, nReset pulled low mid-cycle before the response edge → rsp_valid=00 immediately and stays 0 after release; the next request behaves normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and data-memory lines between the arbiter and its neighbours
interface dmem_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [5:0]  req_f3;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_Wmem;
  logic        mem_Rmem;
  logic [31:0] mem_memOut;
  modport slave (
    input  req_valid, req_write, req_f3, req_addr, req_data, mem_memOut,
    output req_ready, rsp_valid, rsp_err, rsp_data, mem_f3, mem_addr, mem_data, mem_Wmem, mem_Rmem
  );
  modport master (
    output req_valid, req_write, req_f3, req_addr, req_data, mem_memOut,
    input  req_ready, rsp_valid, rsp_err, rsp_data, mem_f3, mem_addr, mem_data, mem_Wmem, mem_Rmem
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access checker in front of the big-endian data memory
module dmem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 8,
  parameter int CW       = 4
) (
  input logic           Clock,
  input logic           nReset,
  dmem_arbiter_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic port;
    logic write;
    logic err;
  } tag_t;
  tag_t          tag_q, tag_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          gnt0, gnt1, go, wr, illegal, err;
  logic [2:0]    f3, size;
  logic [31:0]   addr, data;
  always_comb begin
    gnt1 = nReset && bus.req_valid[1] && (!bus.req_valid[0] || starve_q == CW'(MAX_WAIT));
    gnt0 = nReset && bus.req_valid[0] && !gnt1;
    go   = gnt0 || gnt1;
    wr   = gnt1 ? bus.req_write[1] : bus.req_write[0];
    f3   = gnt1 ? bus.req_f3[5:3] : bus.req_f3[2:0];
    addr = gnt1 ? bus.req_addr[63:32] : bus.req_addr[31:0];
    data = gnt1 ? bus.req_data[63:32] : bus.req_data[31:0];
    size = f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    illegal = f3 == 3'b011 || f3[2:1] == 2'b11 || (wr && f3[2]);
    // 33-bit sum keeps addresses near 2^32 from wrapping into range
    err = illegal || ({1'b0, addr} + 33'(size) > 33'(DEPTH));
    bus.req_ready = {gnt1, gnt0};
    bus.mem_Wmem  = go && wr && !err;
    bus.mem_Rmem  = go && !wr && !err;
    bus.mem_f3    = go && !err ? f3 : 3'd0;
    bus.mem_addr  = go && !err ? addr : 32'd0;
    bus.mem_data  = go && !err ? data : 32'd0;
    starve_d = bus.req_valid[1] && !gnt1 ? (starve_q == CW'(MAX_WAIT) ? starve_q : starve_q + 1'b1) : '0;
    tag_d = {go, gnt1, wr, err};
    bus.rsp_valid = tag_q.valid ? (tag_q.port ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_err   = tag_q.valid && tag_q.err;
    bus.rsp_data  = tag_q.valid && !tag_q.write && !tag_q.err ? bus.mem_memOut : 32'd0;
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tag_q    <= '0;
      starve_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end
endmodule
